// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO between the host bus and the UART transmitter.
// Occupancy-based status flags are registered and sticky error flags feed the status register.
module uart_tx_fifo #(
    parameter int DATA_WIDTH      = 8,
    parameter int FIFO_DEPTH      = 32,
    parameter int ALMOST_FULL_LVL = 28,
    parameter int ADDR_W          = $clog2(FIFO_DEPTH),
    parameter int CNT_W           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wr_req,
    output logic                  full,
    output logic                  almost_full,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  fifo_available,
    input  logic                  fifo_rd,
    output logic [CNT_W-1:0]      occupancy,
    output logic                  overflow_err,
    output logic                  underflow_err,
    input  logic                  err_clr
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(ALMOST_FULL_LVL);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic             full_q, full_d;
    logic             af_q, af_d;
    logic             avail_q, avail_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             wr_ack;
    logic             rd_ack;

    // Acceptance uses the registered flags, so a write to a full FIFO is never passed through by a same-cycle pop.
    assign wr_ack = wr_req & ~full_q;
    assign rd_ack = fifo_rd & avail_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (wr_ack) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_ack) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_ack, rd_ack})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
        full_d  = (occ_d == DEPTH_C);
        af_d    = (occ_d >= AF_C);
        avail_d = (occ_d != '0);
        // A new error event wins over a clear arriving in the same cycle.
        ovf_d   = (ovf_q & ~err_clr) | (wr_req & full_q);
        udf_d   = (udf_q & ~err_clr) | (fifo_rd & ~avail_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            avail_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            full_q   <= full_d;
            af_q     <= af_d;
            avail_q  <= avail_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is deliberately left out of reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_ack) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= data_in;
        end
    end

    assign data_out       = mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign fifo_available = avail_q;
    assign full           = full_q;
    assign almost_full    = af_q;
    assign occupancy      = occ_q;
    assign overflow_err   = ovf_q;
    assign underflow_err  = udf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: fill/drain, wrap-around, simultaneous ops, errors and async reset.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_in;
    logic       wr_req;
    logic       full;
    logic       almost_full;
    logic [7:0] data_out;
    logic       fifo_available;
    logic       fifo_rd;
    logic [5:0] occupancy;
    logic       overflow_err;
    logic       underflow_err;
    logic       err_clr;

    int checks   = 0;
    int failures = 0;
    bit seen_full;

    uart_tx_fifo dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_in        (data_in),
        .wr_req         (wr_req),
        .full           (full),
        .almost_full    (almost_full),
        .data_out       (data_out),
        .fifo_available (fifo_available),
        .fifo_rd        (fifo_rd),
        .occupancy      (occupancy),
        .overflow_err   (overflow_err),
        .underflow_err  (underflow_err),
        .err_clr        (err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        wr_req  = 1'b1;
        data_in = d;
        tick();
        wr_req  = 1'b0;
    endtask

    task automatic pop();
        fifo_rd = 1'b1;
        tick();
        fifo_rd = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        data_in = 8'h00;
        wr_req  = 1'b0;
        fifo_rd = 1'b0;
        err_clr = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();

        chk("rst_avail", fifo_available, 0);
        chk("rst_full", full, 0);
        chk("rst_afull", almost_full, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_ovf", overflow_err, 0);
        chk("rst_udf", underflow_err, 0);

        // Three writes, first-word latency of one cycle
        wr_req  = 1'b1;
        data_in = 8'h41;
        tick();
        chk("fwft_avail", fifo_available, 1);
        chk("fwft_head", data_out, 8'h41);
        data_in = 8'h42;
        tick();
        data_in = 8'h43;
        tick();
        wr_req = 1'b0;
        chk("abc_occ", occupancy, 3);
        chk("abc_head", data_out, 8'h41);
        for (int i = 0; i < 3; i++) begin
            chk("abc_pop_data", data_out, 8'h41 + i);
            pop();
        end
        chk("abc_empty", fifo_available, 0);
        chk("abc_occ0", occupancy, 0);
        chk("abc_udf", underflow_err, 0);

        // Fill to full, then overflow
        for (int n = 1; n <= 32; n++) begin
            push(8'(n - 1));
            chk("fill_afull", almost_full, (n >= 28) ? 1 : 0);
            chk("fill_full", full, (n == 32) ? 1 : 0);
        end
        chk("fill_occ", occupancy, 32);
        chk("pre_ovf", overflow_err, 0);
        push(8'hAA);
        chk("ovf_flag", overflow_err, 1);
        chk("ovf_occ", occupancy, 32);
        chk("ovf_full", full, 1);
        for (int i = 0; i < 32; i++) begin
            chk("drain_data", data_out, i);
            pop();
        end
        chk("drain_empty", fifo_available, 0);
        chk("drain_udf", underflow_err, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("ovf_clr", overflow_err, 0);

        // Wrap-around of the pointers
        seen_full = 1'b0;
        for (int i = 0; i < 20; i++) begin
            push(8'h20 + 8'(i));
            seen_full |= full;
        end
        for (int i = 0; i < 20; i++) begin
            chk("wrap1_data", data_out, 8'h20 + i);
            pop();
        end
        for (int i = 0; i < 20; i++) begin
            push(8'h80 + 8'(i));
            seen_full |= full;
        end
        chk("wrap_occ", occupancy, 20);
        for (int i = 0; i < 20; i++) begin
            chk("wrap2_data", data_out, 8'h80 + i);
            pop();
        end
        chk("wrap_nofull", seen_full, 0);
        chk("wrap_empty", fifo_available, 0);

        // Simultaneous read/write at occupancy 5
        for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
        wr_req  = 1'b1;
        fifo_rd = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data_in = 8'h70 + 8'(i);
            chk("sim_head", data_out, (i < 5) ? (8'h60 + i) : (8'h70 + i - 5));
            tick();
            chk("sim_occ", occupancy, 5);
        end
        wr_req  = 1'b0;
        fifo_rd = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("sim_tail", data_out, 8'h75 + i);
            pop();
        end

        // Write+read while full: read accepted, write rejected
        for (int i = 0; i < 32; i++) push(8'hC0 + 8'(i));
        chk("sf_full", full, 1);
        wr_req  = 1'b1;
        fifo_rd = 1'b1;
        data_in = 8'hEE;
        tick();
        wr_req  = 1'b0;
        fifo_rd = 1'b0;
        chk("sf_occ", occupancy, 31);
        chk("sf_ovf", overflow_err, 1);
        chk("sf_notfull", full, 0);
        chk("sf_head", data_out, 8'hC1);
        for (int i = 1; i < 32; i++) begin
            chk("sf_drain", data_out, 8'hC0 + i);
            pop();
        end
        chk("sf_empty", fifo_available, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("sf_clr", overflow_err, 0);

        // Underflow, clear priority, write-while-empty with read
        pop();
        chk("udf_set", underflow_err, 1);
        chk("udf_occ", occupancy, 0);
        fifo_rd = 1'b1;
        err_clr = 1'b1;
        tick();
        fifo_rd = 1'b0;
        err_clr = 1'b0;
        chk("udf_prio", underflow_err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("udf_clr", underflow_err, 0);
        wr_req  = 1'b1;
        fifo_rd = 1'b1;
        data_in = 8'h5A;
        tick();
        wr_req  = 1'b0;
        fifo_rd = 1'b0;
        chk("we_occ", occupancy, 1);
        chk("we_avail", fifo_available, 1);
        chk("we_data", data_out, 8'h5A);
        chk("we_udf", underflow_err, 1);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 9; i++) push(8'h10 + 8'(i));
        chk("pre_rst_occ", occupancy, 10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_avail", fifo_available, 0);
        chk("arst_occ", occupancy, 0);
        chk("arst_udf", underflow_err, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_avail", fifo_available, 0);
        chk("post_rst_occ", occupancy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
